// File: rtl/sd_otf_convert_if.sv
// Handshake bundle for the signed-digit to two's-complement converter:
// the digit input stream, the word restart strobe and the result word stream.
interface sd_otf_convert_if #(
    parameter int NDIG = 9
) ();
    logic            sync;
    logic [1:0]      in_digit;
    logic            in_valid;
    logic            in_ready;
    logic [NDIG:0]   out_data;
    logic            out_valid;
    logic            out_ready;

    // Digit source plus result consumer side.
    modport master (
        output sync, in_digit, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Converter side.
    modport slave (
        input  sync, in_digit, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sd_otf_convert.sv
// On-the-fly conversion of an MSD-first borrow-save digit stream into a
// two's-complement word. Two candidate prefixes Q and QM = Q-1 are kept so
// each new digit only shifts and selects; no carry chain is ever needed.
module sd_otf_convert #(
    parameter int NDIG = 9
) (
    input  logic              clk,
    input  logic              rst,
    sd_otf_convert_if.slave   bus
);
    // A one-digit word still needs a 1-bit counter to keep the widths legal.
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt, base_cnt;
    logic [NDIG:0]    q, qm, q_nxt, qm_nxt;
    logic [NDIG:0]    base_q, base_qm, sh_q, sh_qm;
    logic [NDIG:0]    out_data_q, out_data_nxt;
    logic             out_valid_q, out_valid_nxt;
    logic             accept, is_pos, is_neg;

    // Input stalls only while a finished word is pending and not being taken.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_pos = (bus.in_digit == 2'b10);
    assign is_neg = (bus.in_digit == 2'b01);

    // Restart selects a fresh word, then the digit appends to Q or QM.
    always_comb begin
        base_cnt = bus.sync ? '0 : cnt;
        base_q   = bus.sync ? '0 : q;
        base_qm  = bus.sync ? '1 : qm;
        sh_q     = {base_q[NDIG-1:0], 1'b0};
        sh_qm    = {base_qm[NDIG-1:0], 1'b1};
        if (is_pos) begin
            sh_q  = {base_q[NDIG-1:0], 1'b1};
            sh_qm = {base_q[NDIG-1:0], 1'b0};
        end else if (is_neg) begin
            sh_q  = {base_qm[NDIG-1:0], 1'b1};
            sh_qm = {base_qm[NDIG-1:0], 1'b0};
        end
    end

    // Word completion loads the output and re-arms Q/QM on the same edge.
    always_comb begin
        cnt_nxt       = base_cnt;
        q_nxt         = base_q;
        qm_nxt        = base_qm;
        out_data_nxt  = out_data_q;
        out_valid_nxt = out_valid_q && !bus.out_ready;
        if (accept) begin
            if (base_cnt == LAST) begin
                out_data_nxt  = sh_q;
                out_valid_nxt = 1'b1;
                cnt_nxt       = '0;
                q_nxt         = '0;
                qm_nxt        = '1;
            end else begin
                cnt_nxt = base_cnt + CNT_W'(1);
                q_nxt   = sh_q;
                qm_nxt  = sh_qm;
            end
        end
    end

    // State registers; reset discards both the partial and the pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            q           <= '0;
            qm          <= '1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            q           <= q_nxt;
            qm          <= qm_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end
endmodule

// File: tb/tb_sd_otf_convert.sv
// Bench for sd_otf_convert: directed scenarios plus random digit streams,
// checked by a queue scoreboard fed from an arithmetic word-value model.
module tb_sd_otf_convert;
    localparam int NDIG = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    bit   rand_mode  = 1'b0;

    logic [NDIG:0] exp_q[$];
    logic [NDIG:0] last_taken = '0;
    int            m_sum = 0;
    int            m_cnt = 0;
    bit            lat_pending = 1'b0;

    sd_otf_convert_if #(.NDIG(NDIG)) bus ();

    sd_otf_convert #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int digit_val(input logic [1:0] d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [NDIG:0] act_v,
                                input logic [NDIG:0] exp_v);
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Reference model: word value is the weighted sum of accepted digits.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            lat_pending = 1'b0;
        end else begin
            if (lat_pending) begin
                check_output("latency_valid", {{NDIG{1'b0}}, bus.out_valid}, 1);
                lat_pending = 1'b0;
            end
            if (bus.sync) begin
                m_sum = 0;
                m_cnt = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                m_sum += digit_val(bus.in_digit) * (1 << (NDIG - 1 - m_cnt));
                m_cnt++;
                if (m_cnt == NDIG) begin
                    exp_q.push_back((NDIG + 1)'(m_sum));
                    m_sum = 0;
                    m_cnt = 0;
                    lat_pending = 1'b1;
                end
            end
        end
    end

    // Monitor: every word handed to the consumer is matched against the queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_word: got %b, expected none", bus.out_data);
            end else begin
                check_output("word", bus.out_data, exp_q.pop_front());
            end
            last_taken = bus.out_data;
        end
    end

    task automatic apply_stimulus(input logic [1:0] d, input logic s);
        bit got = 1'b0;
        int k = 0;
        bus.in_digit = d;
        bus.in_valid = 1'b1;
        bus.sync     = s;
        while (!got && k < 64) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            k++;
            if (!got && rand_mode)
                bus.out_ready = (k >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 64 cycles");
        end
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [1:0] d0, input logic [1:0] d1,
                             input logic [1:0] d2, input logic [1:0] d3);
        apply_stimulus(d0, 1'b0);
        apply_stimulus(d1, 1'b0);
        apply_stimulus(d2, 1'b0);
        apply_stimulus(d3, 1'b0);
    endtask

    // Watchdog so a wedged run still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a random stream.
    initial begin
        int c0;
        rst           = 1'b1;
        bus.sync      = 1'b0;
        bus.in_digit  = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check_output("reset_out_valid", {{NDIG{1'b0}}, bus.out_valid}, 0);
        check_output("reset_out_data", bus.out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("reset_in_ready", {{NDIG{1'b0}}, bus.in_ready}, 1);

        send_word(2'b10, 2'b00, 2'b01, 2'b10);
        idle(2);
        check_output("plus7", last_taken, 5'b00111);

        c0 = cycle;
        send_word(2'b01, 2'b01, 2'b01, 2'b01);
        send_word(2'b10, 2'b10, 2'b10, 2'b10);
        check_output("no_bubble_cycles", (NDIG + 1)'(cycle - c0), 8);
        idle(2);
        check_output("plus15", last_taken, 5'b01111);

        send_word(2'b11, 2'b10, 2'b11, 2'b01);
        idle(2);
        check_output("eleven_is_zero", last_taken, 5'b00011);
        send_word(2'b00, 2'b01, 2'b10, 2'b00);
        idle(2);
        check_output("minus2", last_taken, 5'b11110);

        bus.out_ready = 1'b0;
        send_word(2'b10, 2'b10, 2'b00, 2'b01);
        bus.in_digit = 2'b10;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_in_ready", {{NDIG{1'b0}}, bus.in_ready}, 0);
            check_output("stall_out_valid", {{NDIG{1'b0}}, bus.out_valid}, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send_word(2'b10, 2'b01, 2'b10, 2'b10);
        idle(2);
        check_output("after_stall", last_taken, 5'b00111);

        apply_stimulus(2'b10, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        apply_stimulus(2'b10, 1'b1);
        apply_stimulus(2'b00, 1'b0);
        apply_stimulus(2'b00, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        idle(2);
        check_output("sync_restart", last_taken, 5'b00111);

        bus.out_ready = 1'b0;
        send_word(2'b10, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", {{NDIG{1'b0}}, bus.out_valid}, 0);
        check_output("async_rst_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        apply_stimulus(2'b10, 1'b0);
        apply_stimulus(2'b10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(2'b01, 2'b10, 2'b10, 2'b10);
        idle(2);
        check_output("after_reset_word", last_taken, 5'b11111);

        rand_mode = 1'b1;
        repeat (300) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) idle(1);
            apply_stimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
        end
        rand_mode = 1'b0;
        bus.out_ready = 1'b1;
        idle(NDIG + 4);
        check_output("drain", (NDIG + 1)'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sd_otf_convert.md
# sd_otf_convert

Serial on-the-fly converter from the redundant borrow-save signed-digit format used by the online adders back to conventional two's complement. It accepts one signed digit per cycle, most significant digit first, with a valid/ready handshake, and emits the complete two's-complement word once the last digit of the word has been accepted. It sits at the output end of an online operator chain, turning the digit stream into a binary result without a carry-propagate addition at the end.

## Interface
- NDIG, 9, digits per word (≥1); default matches the result digit count of an 8-stage online adder.
- clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- sync  input  1  synchronous word restart: discards any partial word.
- in_digit  input  2  signed digit {pos,neg}: 10=+1, 01=−1, 00 and 11 = 0.
- in_valid  input  1  in_digit is valid this cycle.
- in_ready  output  1  converter can accept a digit this cycle.
- out_data  output  NDIG+1  two's-complement result word.
- out_valid  output  1  out_data holds a completed, untaken word.
- out_ready  input  1  consumer takes out_data this cycle.

## Operation
- Digit accepted on a rising edge where in_valid && in_ready.
- Word value V = Σ d_i·2^(NDIG−i), i=1..NDIG, d_1 first; range ±(2^NDIG−1); always exact in NDIG+1 bits.
- State: digit counter cnt (0..NDIG−1), registers Q and QM (NDIG+1 bits each, invariant QM = Q−1).
- Word start: Q=0, QM=all ones.
- On an accepted digit d (appending one bit on the right):
  - d=+1: Q←{Q,1}, QM←{Q,0}.
  - d=0: Q←{Q,0}, QM←{QM,1}.
  - d=−1: Q←{QM,1}, QM←{QM,0}.
- No add/subtract in the datapath: shift-and-select only.
- When the accepted digit is the NDIG-th: out_data ← updated Q, out_valid←1, cnt←0, Q/QM re-initialised for the next word in the same edge.
- in_ready = !out_valid || out_ready (combinational; input stalls only while a finished word is pending and not being taken).
- out_valid clears on an edge with out_ready=1, unless a new word completes on that same edge, in which case out_valid stays 1 and out_data loads the new word.
- sync=1: cnt←0, Q/QM re-initialised; has priority over the partial word. A digit accepted in the same cycle is digit 1 of the new word. sync does not touch out_data/out_valid.
- NDIG=1: every accepted digit completes a word.

## Timing
- Reset (asynchronous): out_valid=0, out_data=0, cnt=0, Q=0, QM=all ones; in_ready=1 once Reset deasserts (follows from out_valid=0).
- Throughput: one digit per cycle; one word every NDIG cycles with no bubbles when out_ready stays high.
- Latency: out_valid rises on the same edge that accepts the last digit; the result is visible the cycle after the last digit is presented.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0; held digits are neither lost nor duplicated.
- Reset mid-word discards the partial word and any pending output.
- in_digit is ignored whenever in_valid=0 or in_ready=0.

## Test plan
- NDIG=4, digits +1,0,−1,+1 back-to-back, out_ready=1 -> out_valid for one cycle, out_data=5'b00111 (7).
- NDIG=4, four −1 digits, then four +1 digits without a gap -> 5'b10001 (−15), then 5'b01111 (15) on consecutive word boundaries, no idle cycle.
- NDIG=4, digits 11,10,11,01 -> 11 treated as 0, out_data=5'b00011 (3); digits 0,−1,+1,0 -> 5'b11110 (−2).
- NDIG=4, out_ready=0 after the first word completes, source keeps in_valid=1 -> in_ready=0 and the first word is held; raise out_ready -> the second word's digits resume, and the second result is correct.
- NDIG=4, send 2 digits, assert sync with the 3rd digit (+1), then send 0,0,−1 -> the partial word is discarded, out_data=5'b00111 (8+0+0−1).
- Assert Reset mid-word with out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronous); the following full word converts correctly from fresh state.
